// File: rtl/imm_gen_pkg.sv
// Shared immediate-source encodings and select type for the immediate generator.
// IMM_GEN_ZIMM_EN enables the CSR zimm format on code IMM_Z.
package imm_gen_pkg;
  localparam int IMM_SRC_W = 3;
  typedef logic [IMM_SRC_W-1:0] imm_src_t;

  localparam imm_src_t IMM_I = 3'b000;
  localparam imm_src_t IMM_S = 3'b001;
  localparam imm_src_t IMM_B = 3'b010;
  localparam imm_src_t IMM_U = 3'b011;
  localparam imm_src_t IMM_J = 3'b100;
  localparam imm_src_t IMM_Z = 3'b101;
endpackage

// File: rtl/imm_format_mux.sv
// Combinational RISC-V immediate format mux, sign-extended to XLEN.
// IMM_GEN_ZIMM_EN makes IMM_Z a legal zero-extended instr[19:15] (zimm).
module imm_format_mux
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_src_t        src,
  output logic [XLEN-1:0] imm,
  output logic            err
);
  logic [31:0] imm32;
  logic        unused_opcode;

  // Opcode bits never feed any immediate format.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    imm   = '0;
    case (src)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: err = 1'b1;
    endcase
    imm = XLEN'($signed(imm32));
    if (err) imm = '0;
`ifdef IMM_GEN_ZIMM_EN
    // zimm is zero-extended, unlike every other format.
    if (src == IMM_Z) begin
      err = 1'b0;
      imm = XLEN'(instr[19:15]);
    end
`endif
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator with tag passthrough and flush.
// IMM_GEN_ZIMM_EN (in imm_format_mux) adds the CSR zimm format.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  imm_src_t         in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  logic             s1_valid;
  logic [31:0]      s1_instr;
  imm_src_t         s1_src;
  logic [TAG_W-1:0] s1_tag;
  logic [XLEN-1:0]  mux_imm;
  logic             mux_err;
  logic             advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;

  imm_format_mux #(.XLEN(XLEN)) u_mux (
    .instr (s1_instr),
    .src   (s1_src),
    .imm   (mux_imm),
    .err   (mux_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_instr  <= '0;
      s1_src    <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Output stage only loads real entries, so held data stays put on bubbles.
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_imm <= mux_imm;
          out_tag <= s1_tag;
          out_err <= mux_err;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_instr <= in_instr;
          s1_src   <= in_imm_src;
          s1_tag   <= in_tag;
        end
      end
    end
  end
endmodule
